// File: rtl/ram_2d_pkg.sv
// ram_2d_pkg
// Shared definitions for the 2-D RAM raster reader: default array geometry,
// fixed RAM address widths and the scan FSM state type.
package ram_2d_pkg;

  localparam int ROWS_DEF = 64;
  localparam int COLS_DEF = 32;
  localparam int DW_DEF   = 8;

  // RAM address port widths (row / column)
  localparam int AW_A = 6;
  localparam int AW_B = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

endpackage

// File: rtl/ram_scan_fifo2.sv
// ram_scan_fifo2
// Two-entry output FIFO carrying read data plus its end-of-line and
// end-of-frame tags. The producer guarantees it never pushes when full and
// the consumer only pops when count is non-zero.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   push, push_*      write strobe and entry contents
//   pop               remove head entry
//   head_*            current head entry (stable until popped)
//   count             number of stored entries (0..2)
module ram_scan_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          push_eof,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          head_last,
  output logic          head_eof,
  output logic [1:0]    count
);

  logic [DW-1:0] data_q [2];
  logic [1:0]    last_q;
  logic [1:0]    eof_q;
  logic          wr_ptr;
  logic          rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q    <= '0;
      eof_q     <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= push_data;
        last_q[wr_ptr] <= push_last;
        eof_q[wr_ptr]  <= push_eof;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_data = data_q[rd_ptr];
  assign head_last = last_q[rd_ptr];
  assign head_eof  = eof_q[rd_ptr];

endmodule

// File: rtl/ram_2d_raster_reader.sv
// ram_2d_raster_reader
// Scans a ROWS x COLS synchronous-read RAM once per start request and emits
// every word as a valid/ready stream, tagging the end of each line (m_last)
// and the final word of the scan (m_eof).
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   start                    scan request (ignored while busy)
//   busy, done               scan in progress / one-cycle completion pulse
//   ram_cs, ram_wr           RAM read strobe, write enable (always 0)
//   ram_add_a, ram_add_b     row / column address
//   ram_d_out                RAM read data, one cycle after ram_cs
//   m_data, m_valid, m_ready stream handshake
//   m_last, m_eof            end of line / end of scan tags
//
// Optional feature: RAM_SCAN_COL_MAJOR_EN adds input col_major, sampled on an
// accepted start; when set the row address becomes the fast index.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_SCAN  | issuing reads while the FIFO has room
// ST_DRAIN | all reads issued, waiting for the final beat to be taken
module ram_2d_raster_reader
  import ram_2d_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
`ifdef RAM_SCAN_COL_MAJOR_EN
  input  logic            col_major,
`endif
  output logic            busy,
  output logic            done,
  output logic            ram_cs,
  output logic            ram_wr,
  output logic [AW_A-1:0] ram_add_a,
  output logic [AW_B-1:0] ram_add_b,
  input  logic [DW-1:0]   ram_d_out,
  output logic [DW-1:0]   m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic            m_eof
);

  localparam logic [AW_A-1:0] A_MAX = AW_A'(ROWS - 1);
  localparam logic [AW_B-1:0] B_MAX = AW_B'(COLS - 1);

  scan_state_t     state_q, state_d;
  logic [AW_A-1:0] add_a_q;
  logic [AW_B-1:0] add_b_q;
  logic            inflight_q;
  logic            infl_last_q;
  logic            infl_eof_q;
  logic            done_q;
  logic            rd_issue;
  logic            pop;
  logic [1:0]      fifo_count;
  logic [2:0]      pending;
  logic            head_last;
  logic            head_eof;
  logic            at_a_max;
  logic            at_b_max;
  logic            line_end;
  logic            scan_end;
  logic            col_mode;

`ifdef RAM_SCAN_COL_MAJOR_EN
  logic col_major_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_major_q <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      col_major_q <= col_major;
    end
  end

  assign col_mode = col_major_q;
`else
  assign col_mode = 1'b0;
`endif

  assign at_a_max = (add_a_q == A_MAX);
  assign at_b_max = (add_b_q == B_MAX);
  assign line_end = col_mode ? at_a_max : at_b_max;
  assign scan_end = at_a_max && at_b_max;

  assign m_valid = (fifo_count != 2'd0);
  assign pop     = m_valid && m_ready;

  // Slots already committed: stored words plus the read still in flight,
  // less the word leaving this cycle. A new read needs one free slot.
  assign pending = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d  = state_q;
    rd_issue = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (pending < 3'd2) begin
          rd_issue = 1'b1;
          if (scan_end) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && head_eof) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      add_a_q     <= '0;
      add_b_q     <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      infl_eof_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= rd_issue;
      infl_last_q <= rd_issue && line_end;
      infl_eof_q  <= rd_issue && scan_end;
      done_q      <= (state_q == ST_DRAIN) && pop && head_eof;
      // The final read wraps both indices back to (0,0), so the next scan
      // starts from the origin without reloading the addresses.
      if (rd_issue) begin
        if (col_mode) begin
          if (at_a_max) begin
            add_a_q <= '0;
            add_b_q <= at_b_max ? '0 : add_b_q + AW_B'(1);
          end else begin
            add_a_q <= add_a_q + AW_A'(1);
          end
        end else begin
          if (at_b_max) begin
            add_b_q <= '0;
            add_a_q <= at_a_max ? '0 : add_a_q + AW_A'(1);
          end else begin
            add_b_q <= add_b_q + AW_B'(1);
          end
        end
      end
    end
  end

  ram_scan_fifo2 #(.DW(DW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (ram_d_out),
    .push_last (infl_last_q),
    .push_eof  (infl_eof_q),
    .pop       (pop),
    .head_data (m_data),
    .head_last (head_last),
    .head_eof  (head_eof),
    .count     (fifo_count)
  );

  assign m_last    = m_valid && head_last;
  assign m_eof     = m_valid && head_eof;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign ram_cs    = rd_issue;
  assign ram_wr    = 1'b0;
  assign ram_add_a = add_a_q;
  assign ram_add_b = add_b_q;

endmodule

// File: tb/tb_ram_2d_raster_reader.sv
module tb_ram_2d_raster_reader;

  localparam int ROWS = 64;
  localparam int COLS = 32;
  localparam int DW   = 8;
  localparam int N    = ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          m_ready = 1'b0;
  logic          busy, done, ram_cs, ram_wr;
  logic [5:0]    ram_add_a;
  logic [4:0]    ram_add_b;
  logic [DW-1:0] ram_d_out = '0;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last, m_eof;

  logic [DW-1:0] mem [ROWS][COLS];

  int tests = 0;
  int fails = 0;

  // behavioural model state
  int k = 0;            // index of next expected beat within the scan
  int r = 0;            // index of next expected read
  int out_cnt = 0;      // reads issued but not yet delivered
  int total_beats = 0;
  bit scan_on = 0;
  bit exp_done = 0;
  bit stall = 0;
  logic [DW-1:0] s_data;
  bit s_last, s_eof;

  always #5 clk = ~clk;

  ram_2d_raster_reader #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef RAM_SCAN_COL_MAJOR_EN
    .col_major (1'b0),
`endif
    .busy      (busy),
    .done      (done),
    .ram_cs    (ram_cs),
    .ram_wr    (ram_wr),
    .ram_add_a (ram_add_a),
    .ram_add_b (ram_add_b),
    .ram_d_out (ram_d_out),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .m_eof     (m_eof)
  );

  // synchronous-read RAM: data appears the cycle after a read, held otherwise
  always @(posedge clk) begin
    if (ram_cs) ram_d_out <= mem[ram_add_a][ram_add_b];
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Evaluated at the falling edge, i.e. with the values the DUT will see
  // at the next rising edge.
  task automatic model_check();
    bit pop, eof_exp, was_on;
    int row, col;
    if (!rst_n) begin
      k = 0; r = 0; out_cnt = 0; scan_on = 0; exp_done = 0; stall = 0;
      return;
    end
    chk("busy", busy, scan_on);
    chk("done", done, exp_done);
    chk("ram_wr", ram_wr, 0);
    if (ram_cs) begin
      chk("cs_while_busy", scan_on, 1);
      chk("add_a", ram_add_a, r / COLS);
      chk("add_b", ram_add_b, r % COLS);
      r = (r + 1) % N;
      out_cnt++;
    end
    if (stall) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, s_data);
      chk("stall_last", m_last, s_last);
      chk("stall_eof", m_eof, s_eof);
    end
    pop = m_valid && m_ready;
    eof_exp = 0;
    if (pop) begin
      row = k / COLS;
      col = k % COLS;
      eof_exp = (k == N - 1);
      chk("beat_data", m_data, (row ^ col) & 8'hff);
      chk("beat_last", m_last, (col == COLS - 1) ? 1 : 0);
      chk("beat_eof", m_eof, eof_exp ? 1 : 0);
      if (k == 31) begin
        chk("pin_0_31_data", m_data, 31);
        chk("pin_0_31_last", m_last, 1);
      end
      if (k == 32) begin
        chk("pin_1_0_data", m_data, 1);
        chk("pin_1_0_last", m_last, 0);
      end
      if (k == N - 1) begin
        chk("pin_63_31_data", m_data, 32);
        chk("pin_63_31_last", m_last, 1);
        chk("pin_63_31_eof", m_eof, 1);
      end
      out_cnt--;
      total_beats++;
      k = (k + 1) % N;
    end
    tests++;
    if (out_cnt < 0 || out_cnt > 2) begin
      fails++;
      $display("FAIL outstanding: got %0d expected 0..2 at t=%0t", out_cnt, $time);
    end
    stall  = m_valid && !m_ready;
    s_data = m_data;
    s_last = m_last;
    s_eof  = m_eof;
    exp_done = pop && eof_exp;
    was_on = scan_on;
    if (pop && eof_exp) scan_on = 0;
    if (start && !was_on) scan_on = 1;
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max, input bit toggle, output int n);
    n = 0;
    while (n < max && !done) begin
      if (toggle) m_ready = ~m_ready;
      tick();
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_beat(input int target, input int max);
    int n;
    n = 0;
    while (k != target && n < max) begin
      tick();
      n++;
    end
    chk("reach_beat", k, target);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n, b0;
    for (int a = 0; a < ROWS; a++)
      for (int b = 0; b < COLS; b++)
        mem[a][b] = DW'(a ^ b);

    // reset state
    rst_n = 1'b0;
    m_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cs", ram_cs, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_eof", m_eof, 0);
    chk("rst_data", m_data, 0);
    chk("rst_add_a", ram_add_a, 0);
    chk("rst_add_b", ram_add_b, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // full scan, m_ready held high: first beat at cycle 3, done at 2051
    b0 = total_beats;
    pulse_start();
    chk("c1_valid", m_valid, 0);
    tick();
    chk("c2_valid", m_valid, 0);
    tick();
    chk("c3_valid", m_valid, 1);
    chk("c3_data", m_data, 0);
    n = 3;
    while (!done && n < 3000) begin
      tick();
      n++;
    end
    chk("done_cycle", n, 2051);
    chk("scan1_beats", total_beats - b0, N);
    repeat (3) tick();

    // m_ready toggling every cycle
    b0 = total_beats;
    pulse_start();
    wait_done(6000, 1'b1, n);
    chk("toggle_beats", total_beats - b0, N);
    m_ready = 1'b1;
    repeat (2) tick();

    // stall mid-row, start while busy, start in done cycle
    b0 = total_beats;
    pulse_start();
    wait_beat(40, 100);
    m_ready = 1'b0;
    repeat (10) tick();
    chk("stall_outstanding", out_cnt, 2);
    chk("stall_hold_valid", m_valid, 1);
    m_ready = 1'b1;
    tick();
    chk("resume_valid", m_valid, 1);
    tick();
    chk("resume_valid2", m_valid, 1);
    wait_beat(500, 1000);
    pulse_start();
    chk("ignored_start_busy", busy, 1);
    wait_done(3000, 1'b0, n);
    chk("stall_scan_beats", total_beats - b0, N);
    pulse_start();
    chk("done_cycle_start_busy", busy, 1);

    // reset at beat 700 of the restarted scan
    wait_beat(700, 1000);
    rst_n = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_cs", ram_cs, 0);
    chk("abort_valid", m_valid, 0);
    chk("abort_last", m_last, 0);
    chk("abort_eof", m_eof, 0);
    chk("abort_data", m_data, 0);
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || m_valid) n++;
    end
    chk("abort_quiet", n, 0);

    // rescan from (0,0)
    b0 = total_beats;
    pulse_start();
    wait_done(3000, 1'b0, n);
    chk("rescan_beats", total_beats - b0, N);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
